// File: rtl/eval_exp_ctl_axi4l_responder.sv
// Purpose : AXI4-Lite responder holding the control/status registers of the exp-fp32 DMA calc core.
// Latency : a write response comes one cycle after the last of AW/W handshakes; read data one cycle after AR.
// Backpressure: one outstanding write and one read; readies drop while a response waits for bready/rready.
//
// Ports:
//   s_axi4l_aclk / s_axi4l_aresetn : clock (rising edge) and async active-low reset
//   s_axi4l_aw* / w* / b*          : write address, write data and write response channels
//   s_axi4l_ar* / r*               : read address and read data channels (awprot/arprot ignored)
//   core_start                     : one-cycle start pulse to the core (suppressed while core_busy)
//   core_busy / core_done          : core running level and one-cycle completion pulse
//   core_src_addr / core_dst_addr  : 64-bit DMA source and destination addresses
//   core_size                      : element count, SIZE[31:0]
//   irq                            : registered DONE & IRQ_EN
module eval_exp_ctl_axi4l_responder #(
    parameter int          AXI4L_ADDR_WIDTH = 40,
    parameter int          AXI4L_DATA_WIDTH = 64,
    parameter int          AXI4L_STRB_WIDTH = AXI4L_DATA_WIDTH / 8,
    parameter int          REGADR_BITS      = 8,
    parameter logic [63:0] CORE_ID          = 64'h0000_0000_E8F3_2128
) (
    input  logic                          s_axi4l_aresetn,
    input  logic                          s_axi4l_aclk,
    input  logic [AXI4L_ADDR_WIDTH-1:0]   s_axi4l_awaddr,
    input  logic [2:0]                    s_axi4l_awprot,
    input  logic                          s_axi4l_awvalid,
    output logic                          s_axi4l_awready,
    input  logic [AXI4L_DATA_WIDTH-1:0]   s_axi4l_wdata,
    input  logic [AXI4L_STRB_WIDTH-1:0]   s_axi4l_wstrb,
    input  logic                          s_axi4l_wvalid,
    output logic                          s_axi4l_wready,
    output logic [1:0]                    s_axi4l_bresp,
    output logic                          s_axi4l_bvalid,
    input  logic                          s_axi4l_bready,
    input  logic [AXI4L_ADDR_WIDTH-1:0]   s_axi4l_araddr,
    input  logic [2:0]                    s_axi4l_arprot,
    input  logic                          s_axi4l_arvalid,
    output logic                          s_axi4l_arready,
    output logic [AXI4L_DATA_WIDTH-1:0]   s_axi4l_rdata,
    output logic [1:0]                    s_axi4l_rresp,
    output logic                          s_axi4l_rvalid,
    input  logic                          s_axi4l_rready,
    output logic                          core_start,
    input  logic                          core_busy,
    input  logic                          core_done,
    output logic [63:0]                   core_src_addr,
    output logic [63:0]                   core_dst_addr,
    output logic [31:0]                   core_size,
    output logic                          irq
);

    localparam int IDX_W = REGADR_BITS - 3;
    localparam logic [IDX_W-1:0] N_REGS = IDX_W'(8);

    localparam logic [2:0] RI_ID     = 3'd0;
    localparam logic [2:0] RI_CTL    = 3'd1;
    localparam logic [2:0] RI_STATUS = 3'd2;
    localparam logic [2:0] RI_DCLR   = 3'd3;
    localparam logic [2:0] RI_IRQEN  = 3'd4;
    localparam logic [2:0] RI_SRC    = 3'd5;
    localparam logic [2:0] RI_DST    = 3'd6;
    localparam logic [2:0] RI_SIZE   = 3'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_RESP} rstate_e;

    // Byte-lane merge of a write into a 64-bit register.
    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                                input logic [63:0] new_v,
                                                input logic [7:0]  strb);
        logic [63:0] res;
        res = old_v;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Readies stay low until the first clock after reset release.
    logic rdy_en_q;

    always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
        if (!s_axi4l_aresetn) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_e wstate_q, wstate_d;
    logic    aw_hs, w_hs, wr_fire;

    logic [REGADR_BITS-1:0] aw_off_q;
    logic [63:0]            wdata_q;
    logic [7:0]             wstrb_q;
    logic [1:0]             bresp_q, bresp_d;

    assign s_axi4l_awready = rdy_en_q & ((wstate_q == W_IDLE) | (wstate_q == W_WAIT_AW));
    assign s_axi4l_wready  = rdy_en_q & ((wstate_q == W_IDLE) | (wstate_q == W_WAIT_W));
    assign aw_hs           = s_axi4l_awvalid & s_axi4l_awready;
    assign w_hs            = s_axi4l_wvalid & s_axi4l_wready;
    assign s_axi4l_bvalid  = (wstate_q == W_RESP);
    assign s_axi4l_bresp   = bresp_q;

    always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
        if (!s_axi4l_aresetn) begin
            wstate_q <= W_IDLE;
        end else begin
            wstate_q <= wstate_d;
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        wr_fire  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wstate_d = W_RESP;
                    wr_fire  = 1'b1;
                end else if (aw_hs) begin
                    wstate_d = W_WAIT_W;
                end else if (w_hs) begin
                    wstate_d = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                if (w_hs) begin
                    wstate_d = W_RESP;
                    wr_fire  = 1'b1;
                end
            end
            W_WAIT_AW: begin
                if (aw_hs) begin
                    wstate_d = W_RESP;
                    wr_fire  = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axi4l_bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Hold whichever half of the write arrived first.
    always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
        if (!s_axi4l_aresetn) begin
            aw_off_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_off_q <= s_axi4l_awaddr[REGADR_BITS-1:0];
            end
            if (w_hs) begin
                wdata_q <= s_axi4l_wdata;
                wstrb_q <= s_axi4l_wstrb;
            end
        end
    end

    // Effective write: a channel completing this cycle bypasses its latch.
    logic [REGADR_BITS-1:0] wr_off;
    logic [IDX_W-1:0]       wr_idx;
    logic [63:0]            wr_dat;
    logic [7:0]             wr_strb;
    logic                   wr_mapped;

    assign wr_off    = aw_hs ? s_axi4l_awaddr[REGADR_BITS-1:0] : aw_off_q;
    assign wr_dat    = w_hs ? s_axi4l_wdata : wdata_q;
    assign wr_strb   = w_hs ? s_axi4l_wstrb : wstrb_q;
    assign wr_idx    = wr_off[REGADR_BITS-1:3];
    assign wr_mapped = (wr_idx < N_REGS);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [63:0] src_q, src_d;
    logic [63:0] dst_q, dst_d;
    logic [31:0] size_q, size_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        start_q, start_d;
    logic        irq_q, irq_d;
    logic        done_clr;
    logic [63:0] size_merged;

    assign size_merged = merge_bytes({32'd0, size_q}, wr_dat, wr_strb);

    always_comb begin
        src_d    = src_q;
        dst_d    = dst_q;
        size_d   = size_q;
        irq_en_d = irq_en_q;
        start_d  = 1'b0;
        done_clr = 1'b0;
        bresp_d  = bresp_q;
        if (wr_fire) begin
            bresp_d = wr_mapped ? RESP_OKAY : RESP_SLVERR;
        end
        if (wr_fire && wr_mapped) begin
            case (wr_idx[2:0])
                RI_CTL:   start_d  = wr_strb[0] & wr_dat[0] & ~core_busy;
                RI_DCLR:  done_clr = wr_strb[0] & wr_dat[0];
                RI_IRQEN: if (wr_strb[0]) irq_en_d = wr_dat[0];
                RI_SRC:   src_d    = merge_bytes(src_q, wr_dat, wr_strb);
                RI_DST:   dst_d    = merge_bytes(dst_q, wr_dat, wr_strb);
                RI_SIZE:  size_d   = size_merged[31:0];
                default:  ;
            endcase
        end
        // A completion in the same cycle as a clear keeps DONE set.
        done_d = core_done | (done_q & ~done_clr);
        irq_d  = done_q & irq_en_q;
    end

    always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
        if (!s_axi4l_aresetn) begin
            src_q    <= '0;
            dst_q    <= '0;
            size_q   <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            size_q   <= size_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            start_q  <= start_d;
            irq_q    <= irq_d;
            bresp_q  <= bresp_d;
        end
    end

    assign core_start    = start_q;
    assign core_src_addr = src_q;
    assign core_dst_addr = dst_q;
    assign core_size     = size_q;
    assign irq           = irq_q;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_e          rstate_q, rstate_d;
    logic             ar_hs;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_mapped;
    logic [63:0]      rd_dat, rdata_q;
    logic [1:0]       rd_resp, rresp_q;

    assign s_axi4l_arready = rdy_en_q & (rstate_q == R_IDLE);
    assign ar_hs           = s_axi4l_arvalid & s_axi4l_arready;
    assign s_axi4l_rvalid  = (rstate_q == R_RESP);
    assign s_axi4l_rdata   = rdata_q;
    assign s_axi4l_rresp   = rresp_q;
    assign rd_idx          = s_axi4l_araddr[REGADR_BITS-1:3];
    assign rd_mapped       = (rd_idx < N_REGS);

    always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
        if (!s_axi4l_aresetn) begin
            rstate_q <= R_IDLE;
        end else begin
            rstate_q <= rstate_d;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_RESP;
            R_RESP:  if (s_axi4l_rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        rd_dat  = '0;
        rd_resp = RESP_OKAY;
        if (!rd_mapped) begin
            rd_resp = RESP_SLVERR;
        end else begin
            case (rd_idx[2:0])
                RI_ID:     rd_dat = CORE_ID;
                RI_STATUS: rd_dat = {62'd0, done_q, core_busy};
                RI_IRQEN:  rd_dat = {63'd0, irq_en_q};
                RI_SRC:    rd_dat = src_q;
                RI_DST:    rd_dat = dst_q;
                RI_SIZE:   rd_dat = {32'd0, size_q};
                default:   rd_dat = '0;
            endcase
        end
    end

    // Read data is captured at the AR handshake and held until rready.
    always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
        if (!s_axi4l_aresetn) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_dat;
            rresp_q <= rd_resp;
        end
    end

    // Protection bits, undecoded upper address bits and the byte offset are don't-care.
    logic unused_bits;
    assign unused_bits = ^{s_axi4l_awprot, s_axi4l_arprot,
                           s_axi4l_awaddr[AXI4L_ADDR_WIDTH-1:REGADR_BITS], s_axi4l_awaddr[2:0],
                           s_axi4l_araddr[AXI4L_ADDR_WIDTH-1:REGADR_BITS], s_axi4l_araddr[2:0],
                           aw_off_q[2:0]};

endmodule

// File: tb/tb_eval_exp_ctl_axi4l_responder.sv
// Purpose : randomized and directed bench for the exp-fp32 control register responder.
// Latency : checks one-cycle write/read response latency against a register-map reference.
// Backpressure: holds bready/rready low for random spans and checks responses stay stable.
module tb_eval_exp_ctl_axi4l_responder;

    localparam logic [63:0] CORE_ID = 64'h0000_0000_E8F3_2128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [39:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        core_start;
    logic        core_busy;
    logic        core_done;
    logic [63:0] core_src_addr;
    logic [63:0] core_dst_addr;
    logic [31:0] core_size;
    logic        irq;

    always #5 clk = ~clk;

    eval_exp_ctl_axi4l_responder dut (
        .s_axi4l_aresetn (rst_n),
        .s_axi4l_aclk    (clk),
        .s_axi4l_awaddr  (awaddr),
        .s_axi4l_awprot  (awprot),
        .s_axi4l_awvalid (awvalid),
        .s_axi4l_awready (awready),
        .s_axi4l_wdata   (wdata),
        .s_axi4l_wstrb   (wstrb),
        .s_axi4l_wvalid  (wvalid),
        .s_axi4l_wready  (wready),
        .s_axi4l_bresp   (bresp),
        .s_axi4l_bvalid  (bvalid),
        .s_axi4l_bready  (bready),
        .s_axi4l_araddr  (araddr),
        .s_axi4l_arprot  (arprot),
        .s_axi4l_arvalid (arvalid),
        .s_axi4l_arready (arready),
        .s_axi4l_rdata   (rdata),
        .s_axi4l_rresp   (rresp),
        .s_axi4l_rvalid  (rvalid),
        .s_axi4l_rready  (rready),
        .core_start      (core_start),
        .core_busy       (core_busy),
        .core_done       (core_done),
        .core_src_addr   (core_src_addr),
        .core_dst_addr   (core_dst_addr),
        .core_size       (core_size),
        .irq             (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference register map.
    logic [63:0] m_src, m_dst;
    logic [31:0] m_size;
    logic        m_irq_en, m_done;
    int          exp_starts;

    // Start pulses seen at the falling edge; a pulse lasting two cycles is caught.
    int obs_starts = 0;
    int long_pulses = 0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (core_start) begin
            obs_starts++;
            if (prev_start) long_pulses++;
        end
        prev_start = core_start;
    end

    task automatic model_reset();
        m_src = '0; m_dst = '0; m_size = '0; m_irq_en = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_write(input logic [39:0] a, input logic [63:0] d, input logic [7:0] s,
                               output logic [1:0] resp);
        logic [63:0] sz;
        int idx;
        idx  = int'(a[7:3]);
        resp = (idx < 8) ? 2'b00 : 2'b10;
        sz   = {32'd0, m_size};
        for (int i = 0; i < 8; i++) begin
            if (s[i]) begin
                if (idx == 5) m_src[8*i +: 8] = d[8*i +: 8];
                if (idx == 6) m_dst[8*i +: 8] = d[8*i +: 8];
                if (idx == 7) sz[8*i +: 8] = d[8*i +: 8];
            end
        end
        m_size = sz[31:0];
        if (idx == 1 && s[0] && d[0] && !core_busy) exp_starts++;
        if (idx == 3 && s[0] && d[0]) m_done = 1'b0;
        if (idx == 4 && s[0]) m_irq_en = d[0];
    endtask

    task automatic model_read(input logic [39:0] a, output logic [63:0] d, output logic [1:0] resp);
        d = '0;
        resp = 2'b00;
        case (int'(a[7:3]))
            0: d = CORE_ID;
            2: d = {62'd0, m_done, core_busy};
            4: d = {63'd0, m_irq_en};
            5: d = m_src;
            6: d = m_dst;
            7: d = {32'd0, m_size};
            1, 3: d = '0;
            default: resp = 2'b10;
        endcase
    endtask

    task automatic axi_wr(input logic [39:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int aw_dly, input int w_dly, input int b_dly, input bit pulse_done,
                          output bit start_seen, output bit irq_seen);
        bit aw_done = 0, w_done = 0, aw_f, w_f;
        int cyc = 0;
        logic [1:0] er;
        model_write(a, d, s, er);
        if (pulse_done) m_done = 1'b1;
        awaddr = a; wdata = d; wstrb = s;
        start_seen = 0; irq_seen = 0;
        while (!(aw_done && w_done) && cyc < 64) begin
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            core_done = pulse_done && (aw_done || aw_f) && (w_done || w_f);
            @(posedge clk); #1;
            core_done = 1'b0;
            aw_done |= aw_f;
            w_done  |= w_f;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            chk("wr_handshake_timeout", 64'd0, 64'd1);
            return;
        end
        chk("bvalid_latency", 64'(bvalid), 64'd1);
        chk("bresp", 64'(bresp), 64'(er));
        chk("awready_in_resp", 64'(awready | wready), 64'd0);
        start_seen = core_start;
        irq_seen = irq;
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            chk("bvalid_hold", 64'(bvalid), 64'd1);
            chk("bresp_hold", 64'(bresp), 64'(er));
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("bvalid_clear", 64'(bvalid), 64'd0);
    endtask

    task automatic axi_rd(input logic [39:0] a, input int ar_dly, input int r_dly);
        logic [63:0] ed;
        logic [1:0]  er;
        bit f = 0;
        int cyc = 0;
        model_read(a, ed, er);
        araddr = a;
        while (!f && cyc < 64) begin
            arvalid = cyc >= ar_dly;
            f = arvalid && arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        if (!f) begin
            chk("rd_handshake_timeout", 64'd0, 64'd1);
            return;
        end
        chk("rvalid_latency", 64'(rvalid), 64'd1);
        chk("rdata", rdata, ed);
        chk("rresp", 64'(rresp), 64'(er));
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            chk("rdata_hold", rdata, ed);
            chk("rresp_hold", 64'(rresp), 64'(er));
            chk("rvalid_hold", 64'(rvalid), 64'd1);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("rvalid_clear", 64'(rvalid), 64'd0);
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        m_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_core(input string tag);
        chk({tag, "_src"}, core_src_addr, m_src);
        chk({tag, "_dst"}, core_dst_addr, m_dst);
        chk({tag, "_size"}, 64'(core_size), 64'(m_size));
        chk({tag, "_irq"}, 64'(irq), 64'(m_done & m_irq_en));
    endtask

    initial begin
        bit st, iq;
        logic [39:0] a;
        logic [63:0] d;
        int idx;

        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arprot = '0; arvalid = 0; rready = 0;
        core_busy = 0; core_done = 0;
        exp_starts = 0;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readies", 64'({awready, wready, arready}), 64'd0);
        chk("rst_valids", 64'({bvalid, rvalid}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_resps", 64'({bresp, rresp}), 64'd0);
        chk("rst_core", 64'({core_start, irq}), 64'd0);
        chk_core("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_readies", 64'({awready, wready, arready}), 64'd7);

        // Same-cycle AW+W, then readback.
        axi_wr(40'h28, 64'h0000_0000_1000_0000, 8'hFF, 0, 0, 0, 0, st, iq);
        axi_rd(40'h28, 0, 0);
        chk_core("src_write");

        // W one cycle ahead of AW; upper half of SIZE discarded.
        axi_wr(40'h38, 64'hFFFF_FFFF_0000_0080, 8'hFF, 1, 0, 0, 0, st, iq);
        chk("size_out", 64'(core_size), 64'h80);
        axi_rd(40'h38, 0, 0);

        // Partial strobe.
        axi_wr(40'h28, 64'h0, 8'hFF, 0, 2, 0, 0, st, iq);
        axi_wr(40'h28, 64'h1122_3344_5566_7788, 8'h0F, 0, 0, 0, 0, st, iq);
        chk("src_strb", core_src_addr, 64'h0000_0000_5566_7788);
        axi_rd(40'h28, 1, 0);

        // Start pulse: idle, busy, and without strb[0].
        axi_wr(40'h08, 64'h1, 8'h01, 0, 0, 0, 0, st, iq);
        chk("start_idle", 64'(st), 64'd1);
        core_busy = 1'b1;
        axi_wr(40'h08, 64'h1, 8'h01, 0, 0, 0, 0, st, iq);
        chk("start_busy", 64'(st), 64'd0);
        core_busy = 1'b0;
        axi_wr(40'h08, 64'h1, 8'hFE, 0, 0, 0, 0, st, iq);
        chk("start_nostrb", 64'(st), 64'd0);
        axi_rd(40'h08, 0, 0);

        // DONE / IRQ behaviour.
        axi_wr(40'h20, 64'h1, 8'h01, 0, 0, 0, 0, st, iq);
        pulse_done();
        chk("irq_set", 64'(irq), 64'd1);
        axi_rd(40'h10, 0, 0);
        axi_wr(40'h18, 64'h1, 8'h01, 0, 0, 0, 1, st, iq);
        axi_rd(40'h10, 0, 0);
        chk("irq_clr_vs_done", 64'(irq), 64'd1);
        axi_wr(40'h18, 64'h1, 8'h01, 0, 0, 0, 0, st, iq);
        chk("irq_lag", 64'(iq), 64'd1);
        chk("irq_cleared", 64'(irq), 64'd0);
        axi_rd(40'h10, 0, 0);

        // Unmapped access with held-off response channels; ID register.
        axi_rd(40'hF0, 0, 5);
        axi_wr(40'hF0, 64'hDEAD_BEEF, 8'hFF, 0, 0, 5, 0, st, iq);
        axi_rd(40'h00, 0, 0);
        axi_rd(40'hAB_CDEF_FF04, 0, 0);

        // Concurrent write and read.
        fork
            axi_wr(40'h30, 64'hCAFE_F00D_1234_5678, 8'hFF, 1, 0, 2, 0, st, iq);
            axi_rd(40'h28, 0, 3);
        join
        chk_core("concurrent");

        // Randomized traffic.
        for (int it = 0; it < 200; it++) begin
            a = {$urandom, $urandom};
            idx = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 31) : $urandom_range(0, 7);
            a[7:3] = idx[4:0];
            d = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) d[0] = 1'b1;
            if ($urandom_range(0, 7) == 0) core_busy = ~core_busy;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: axi_wr(a, d, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                                   $urandom_range(0, 3), ($urandom_range(0, 3) == 0), st, iq);
                4, 5, 6, 7, 8: axi_rd(a, $urandom_range(0, 2), $urandom_range(0, 3));
                default: pulse_done();
            endcase
            chk_core("rand");
        end

        // Reset in the middle of a pending write response.
        core_busy = 1'b0;
        awaddr = 40'h28; wdata = 64'h55; wstrb = 8'hFF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        chk("pre_rst_bvalid", 64'(bvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_bvalid", 64'(bvalid), 64'd0);
        chk("midrst_readies", 64'({awready, wready, arready}), 64'd0);
        chk_core("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_rd(40'h28, 0, 0);
        axi_rd(40'h10, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("start_count", 64'(obs_starts), 64'(exp_starts));
        chk("start_width", 64'(long_pulses), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
